// File: rtl/hazard_ctrl_gen_pkg.sv
// Shared constants for the hazard/forwarding controller.
// - Forward select codes: FWD_RF picks the register file; STG_E/M/W are the post-decode
//   stage indices that a forward select can name.
// - Typical Tnew codes, in cycles after entering E until the result can be forwarded.
// - Tuse codes, in cycles from D until a source is consumed.
package hazard_ctrl_gen_pkg;

  localparam int unsigned FWD_RF = 0;
  localparam int unsigned STG_E  = 1;
  localparam int unsigned STG_M  = 2;
  localparam int unsigned STG_W  = 3;

  localparam int unsigned TNEW_ALU  = 1;
  localparam int unsigned TNEW_LOAD = 2;
  localparam int unsigned TNEW_MFHI = 1;

  localparam int unsigned TUSE_D = 0;
  localparam int unsigned TUSE_E = 1;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hazard_ctrl_gen_if.sv
// Decode-side bundle between the pipeline and the hazard controller.
// master: decode stage (drives the D-stage instruction fields, receives stall/forward).
// slave : hazard controller.
//   d_valid, d_src, d_tuse, d_dst, d_tnew, d_md_start, d_md_div, d_md_use : D-stage info
//   stall, fwd_d, fwd_e, md_busy                                      : controller results
interface hazard_ctrl_gen_if #(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned AW    = 5,
  parameter int unsigned NSRC  = 2,
  parameter int unsigned TW    = 2,
  parameter int unsigned SW    = $clog2(DEPTH + 1)
);

  logic                 d_valid;
  logic [NSRC*AW-1:0]   d_src;
  logic [NSRC*TW-1:0]   d_tuse;
  logic [AW-1:0]        d_dst;
  logic [TW-1:0]        d_tnew;
  logic                 d_md_start;
  logic                 d_md_div;
  logic                 d_md_use;
  logic                 stall;
  logic [NSRC*SW-1:0]   fwd_d;
  logic [NSRC*SW-1:0]   fwd_e;
  logic                 md_busy;

  modport master (
    output d_valid, d_src, d_tuse, d_dst, d_tnew, d_md_start, d_md_div, d_md_use,
    input  stall, fwd_d, fwd_e, md_busy
  );

  modport slave (
    input  d_valid, d_src, d_tuse, d_dst, d_tnew, d_md_start, d_md_div, d_md_use,
    output stall, fwd_d, fwd_e, md_busy
  );

endinterface

// File: rtl/hazard_md_timer.sv
// Multiply/divide occupancy timer.
// Ports:
//   clk, rst     : clock, asynchronous active-low reset
//   start_i      : a non-stalled mult/div start is leaving D this cycle
//   div_i        : with start_i, the operation is a divide
//   md_busy_o    : unit occupied (counter non-zero)
//   start_e_o    : a mult/div start sits in E this cycle
module hazard_md_timer
  import hazard_ctrl_gen_pkg::*;
#(
  parameter int unsigned MUL_CYC = 5,
  parameter int unsigned DIV_CYC = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic div_i,
  output logic md_busy_o,
  output logic start_e_o
);

  localparam int unsigned CW = $clog2(max_u(MUL_CYC, DIV_CYC) + 1);

  logic [CW-1:0] cnt_d, cnt_q;
  logic          start_e_d, start_e_q;

  always_comb begin
    cnt_d     = cnt_q;
    start_e_d = start_i;
    if (start_i) begin
      cnt_d = div_i ? CW'(DIV_CYC) : CW'(MUL_CYC);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      start_e_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      start_e_q <= start_e_d;
    end
  end

  assign md_busy_o = (cnt_q != '0);
  assign start_e_o = start_e_q;

endmodule

// File: rtl/hazard_ctrl_gen.sv
// Tnew/Tuse scoreboard hazard and forwarding controller.
// Ports:
//   clk, rst : clock, asynchronous active-low reset
//   hz       : slave side of hazard_ctrl_gen_if (D-stage fields in; stall, fwd_d,
//              fwd_e, md_busy out)
// Scoreboard slot j holds the instruction at post-decode stage j+1 (0 = E).
module hazard_ctrl_gen
  import hazard_ctrl_gen_pkg::*;
#(
  parameter int unsigned DEPTH   = 3,
  parameter int unsigned AW      = 5,
  parameter int unsigned NSRC    = 2,
  parameter int unsigned TW      = 2,
  parameter int unsigned MUL_CYC = 5,
  parameter int unsigned DIV_CYC = 10,
  parameter int unsigned SW      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  hazard_ctrl_gen_if.slave hz
);

  logic          ent_vld_d  [DEPTH];
  logic          ent_vld_q  [DEPTH];
  logic [AW-1:0] ent_dst_d  [DEPTH];
  logic [AW-1:0] ent_dst_q  [DEPTH];
  logic [TW-1:0] ent_trem_d [DEPTH];
  logic [TW-1:0] ent_trem_q [DEPTH];

  logic [NSRC*AW-1:0] e_src_d, e_src_q;

  logic [NSRC-1:0] src_stall;
  logic            stall;
  logic            md_stall;
  logic            md_start;
  logic            md_busy;
  logic            md_start_e;

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    logic [AW-1:0] src, e_src;
    logic [TW-1:0] tuse;
    logic          d_hit, e_hit;
    logic [SW-1:0] d_stg, e_stg;
    logic [TW-1:0] d_trem, e_trem;

    assign src   = hz.d_src[i*AW +: AW];
    assign e_src = e_src_q[i*AW +: AW];
    assign tuse  = hz.d_tuse[i*TW +: TW];

    // Scan oldest to youngest so the youngest match is the one left standing.
    always_comb begin
      d_hit  = 1'b0;
      d_stg  = '0;
      d_trem = '0;
      for (int j = int'(DEPTH) - 1; j >= 0; j--) begin
        if (ent_vld_q[j] && (ent_dst_q[j] == src) && (src != '0)) begin
          d_hit  = 1'b1;
          d_stg  = SW'(j + 1);
          d_trem = ent_trem_q[j];
        end
      end
    end

    // The E instruction occupies slot 0 itself, so its producers start at slot 1.
    always_comb begin
      e_hit  = 1'b0;
      e_stg  = '0;
      e_trem = '0;
      for (int j = int'(DEPTH) - 1; j >= 1; j--) begin
        if (ent_vld_q[j] && (ent_dst_q[j] == e_src) && (e_src != '0)) begin
          e_hit  = 1'b1;
          e_stg  = SW'(j + 1);
          e_trem = ent_trem_q[j];
        end
      end
    end

    assign src_stall[i]          = d_hit && (d_trem > tuse);
    assign hz.fwd_d[i*SW +: SW]  = (d_hit && (d_trem == '0)) ? d_stg : SW'(FWD_RF);
    assign hz.fwd_e[i*SW +: SW]  = (e_hit && (e_trem == '0)) ? e_stg : SW'(FWD_RF);
  end

  assign md_stall = hz.d_md_use && (md_busy || md_start_e);
  assign stall    = hz.d_valid && ((|src_stall) || md_stall);
  assign md_start = hz.d_valid && hz.d_md_start && !stall;

  always_comb begin
    // A stalled or empty D turns into a bubble in E.
    ent_vld_d[0]  = hz.d_valid && !stall;
    ent_dst_d[0]  = hz.d_dst;
    ent_trem_d[0] = hz.d_tnew;
    for (int j = 1; j < int'(DEPTH); j++) begin
      ent_vld_d[j]  = ent_vld_q[j-1];
      ent_dst_d[j]  = ent_dst_q[j-1];
      ent_trem_d[j] = (ent_trem_q[j-1] == '0) ? '0 : ent_trem_q[j-1] - TW'(1);
    end
    e_src_d = stall ? '0 : hz.d_src;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent_vld_q  <= '{default: '0};
      ent_dst_q  <= '{default: '0};
      ent_trem_q <= '{default: '0};
      e_src_q    <= '0;
    end else begin
      ent_vld_q  <= ent_vld_d;
      ent_dst_q  <= ent_dst_d;
      ent_trem_q <= ent_trem_d;
      e_src_q    <= e_src_d;
    end
  end

  hazard_md_timer #(
    .MUL_CYC (MUL_CYC),
    .DIV_CYC (DIV_CYC)
  ) u_md_timer (
    .clk       (clk),
    .rst       (rst),
    .start_i   (md_start),
    .div_i     (hz.d_md_div),
    .md_busy_o (md_busy),
    .start_e_o (md_start_e)
  );

  assign hz.stall   = stall;
  assign hz.md_busy = md_busy;

endmodule

// File: tb/tb_hazard_ctrl_gen.sv
// Directed bench for hazard_ctrl_gen: inputs change 1 ns after the rising edge and
// outputs are checked 1 ns later, well clear of the next edge.
module tb_hazard_ctrl_gen;
  import hazard_ctrl_gen_pkg::*;

  localparam int unsigned DEPTH   = 3;
  localparam int unsigned AW      = 5;
  localparam int unsigned NSRC    = 2;
  localparam int unsigned TW      = 2;
  localparam int unsigned MUL_CYC = 5;
  localparam int unsigned DIV_CYC = 10;
  localparam int unsigned SW      = 2;

  logic clk = 1'b0;
  logic rst;
  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl_gen_if #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .NSRC  (NSRC),
    .TW    (TW),
    .SW    (SW)
  ) hz ();

  hazard_ctrl_gen #(
    .DEPTH   (DEPTH),
    .AW      (AW),
    .NSRC    (NSRC),
    .TW      (TW),
    .MUL_CYC (MUL_CYC),
    .DIV_CYC (DIV_CYC),
    .SW      (SW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  task automatic drive(input logic v, input int s0, input int s1, input int u0, input int u1,
                       input int dst, input int tnew, input logic ms, input logic mdv,
                       input logic mu);
    hz.d_valid    = v;
    hz.d_src      = {AW'(s1), AW'(s0)};
    hz.d_tuse     = {TW'(u1), TW'(u0)};
    hz.d_dst      = AW'(dst);
    hz.d_tnew     = TW'(tnew);
    hz.d_md_start = ms;
    hz.d_md_div   = mdv;
    hz.d_md_use   = mu;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".stall"}, 32'(hz.stall), 0);
    chk({tag, ".fwd_d"}, 32'(hz.fwd_d), 0);
    chk({tag, ".fwd_e"}, 32'(hz.fwd_e), 0);
    chk({tag, ".md_busy"}, 32'(hz.md_busy), 0);
  endtask

  initial begin
    rst = 1'b0;
    idle();
    #1;
    chk_quiet("reset");
    tick();
    rst = 1'b1;

    // Load-use: lw $8 then addu reading $8 with tuse=1.
    drive(1'b1, 29, 0, TUSE_E, 0, 8, TNEW_LOAD, 1'b0, 1'b0, 1'b0);
    chk("lu.lw.stall", 32'(hz.stall), 0);
    tick();
    drive(1'b1, 8, 9, TUSE_E, TUSE_E, 10, TNEW_ALU, 1'b0, 1'b0, 1'b0);
    chk("lu.stall1", 32'(hz.stall), 1);
    chk("lu.fwd_d1", 32'(hz.fwd_d), 0);
    tick();
    drive(1'b1, 8, 9, TUSE_E, TUSE_E, 10, TNEW_ALU, 1'b0, 1'b0, 1'b0);
    chk("lu.stall2", 32'(hz.stall), 0);
    chk("lu.fwd_e_bubble", 32'(hz.fwd_e), 0);
    tick();
    idle();
    chk("lu.fwd_e_w", 32'(hz.fwd_e), STG_W);  // src0 <- W, src1 regfile
    tick();

    // ALU -> branch: addu $9, then beq $9,$10 with tuse=0; $10 already in W.
    drive(1'b1, 1, 2, TUSE_E, TUSE_E, 9, TNEW_ALU, 1'b0, 1'b0, 1'b0);
    chk("br.addu.stall", 32'(hz.stall), 0);
    tick();
    drive(1'b1, 9, 10, TUSE_D, TUSE_D, 0, 0, 1'b0, 1'b0, 1'b0);
    chk("br.stall1", 32'(hz.stall), 1);
    chk("br.fwd_d1", 32'(hz.fwd_d), 32'hc);  // src1 <- W (3), src0 waits
    tick();
    drive(1'b1, 9, 10, TUSE_D, TUSE_D, 0, 0, 1'b0, 1'b0, 1'b0);
    chk("br.stall2", 32'(hz.stall), 0);
    chk("br.fwd_d2", 32'(hz.fwd_d), STG_M);
    tick();
    idle();
    chk("br.fwd_e", 32'(hz.fwd_e), STG_W);
    tick();

    // Shadowing: addu $5 ahead of lw $5; the younger lw governs.
    drive(1'b1, 1, 2, TUSE_E, TUSE_E, 5, TNEW_ALU, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 29, 0, TUSE_E, 0, 5, TNEW_LOAD, 1'b0, 1'b0, 1'b0);
    chk("sh.lw.stall", 32'(hz.stall), 0);
    tick();
    drive(1'b1, 5, 0, TUSE_E, 0, 6, TNEW_ALU, 1'b0, 1'b0, 1'b0);
    chk("sh.stall1", 32'(hz.stall), 1);
    chk("sh.fwd_d1", 32'(hz.fwd_d), 0);
    tick();
    drive(1'b1, 5, 0, TUSE_E, 0, 6, TNEW_ALU, 1'b0, 1'b0, 1'b0);
    chk("sh.stall2", 32'(hz.stall), 0);
    chk("sh.fwd_d2", 32'(hz.fwd_d), 0);
    tick();
    idle();
    chk("sh.fwd_e", 32'(hz.fwd_e), STG_W);
    tick();

    // $0 everywhere never creates a hazard.
    for (int n = 0; n < 3; n++) begin
      drive(1'b1, 0, 0, TUSE_D, TUSE_D, 0, TNEW_LOAD, 1'b0, 1'b0, 1'b0);
      chk("zero.stall", 32'(hz.stall), 0);
      chk("zero.fwd_d", 32'(hz.fwd_d), 0);
      tick();
    end
    drive(1'b1, 0, 0, TUSE_D, TUSE_D, 0, 0, 1'b0, 1'b0, 1'b0);
    chk_quiet("zero.full");
    tick();

    // d_valid=0 masks a would-be stall.
    drive(1'b1, 29, 0, TUSE_E, 0, 7, TNEW_LOAD, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 7, 0, TUSE_D, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    chk("inv.stall", 32'(hz.stall), 0);
    tick();
    for (int n = 0; n < 3; n++) begin
      idle();
      tick();
    end

    // div then mfhi: 10 busy cycles.
    drive(1'b1, 0, 0, 0, 0, 0, 0, 1'b1, 1'b1, 1'b1);
    chk("div.stall", 32'(hz.stall), 0);
    chk("div.busy0", 32'(hz.md_busy), 0);
    tick();
    for (int n = 0; n < 10; n++) begin
      drive(1'b1, 0, 0, 0, 0, 2, TNEW_MFHI, 1'b0, 1'b0, 1'b1);
      chk($sformatf("div.busy%0d", n), 32'(hz.md_busy), 1);
      chk($sformatf("div.mfhi_stall%0d", n), 32'(hz.stall), 1);
      tick();
    end
    drive(1'b1, 0, 0, 0, 0, 2, TNEW_MFHI, 1'b0, 1'b0, 1'b1);
    chk("div.busy_end", 32'(hz.md_busy), 0);
    chk("div.mfhi_go", 32'(hz.stall), 0);
    tick();
    idle();
    tick();

    // mult then mfhi: 5 busy cycles.
    drive(1'b1, 0, 0, 0, 0, 0, 0, 1'b1, 1'b0, 1'b1);
    chk("mul.stall", 32'(hz.stall), 0);
    tick();
    for (int n = 0; n < 5; n++) begin
      drive(1'b1, 0, 0, 0, 0, 2, TNEW_MFHI, 1'b0, 1'b0, 1'b1);
      chk($sformatf("mul.busy%0d", n), 32'(hz.md_busy), 1);
      chk($sformatf("mul.mfhi_stall%0d", n), 32'(hz.stall), 1);
      tick();
    end
    drive(1'b1, 0, 0, 0, 0, 2, TNEW_MFHI, 1'b0, 1'b0, 1'b1);
    chk("mul.busy_end", 32'(hz.md_busy), 0);
    chk("mul.mfhi_go", 32'(hz.stall), 0);
    tick();
    idle();
    tick();

    // Reset mid-operation with md_cnt=4 and live entries.
    drive(1'b1, 29, 0, TUSE_E, 0, 8, TNEW_LOAD, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 0, 0, 0, 0, 0, 0, 1'b1, 1'b0, 1'b1);
    chk("rs.mult.stall", 32'(hz.stall), 0);
    tick();
    drive(1'b1, 8, 0, TUSE_E, 0, 11, TNEW_ALU, 1'b0, 1'b0, 1'b0);
    chk("rs.addu.stall", 32'(hz.stall), 0);
    tick();
    drive(1'b1, 11, 8, TUSE_D, TUSE_D, 12, TNEW_ALU, 1'b0, 1'b0, 1'b1);
    chk("rs.pre.stall", 32'(hz.stall), 1);
    chk("rs.pre.fwd_d", 32'(hz.fwd_d), 32'hc);
    chk("rs.pre.fwd_e", 32'(hz.fwd_e), STG_W);
    chk("rs.pre.busy", 32'(hz.md_busy), 1);
    #1;
    rst = 1'b0;
    #1;
    chk_quiet("rs.during");
    idle();
    #1;
    rst = 1'b1;
    tick();
    drive(1'b1, 11, 8, TUSE_D, TUSE_D, 0, 0, 1'b0, 1'b0, 1'b1);
    chk_quiet("rs.after");
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
